// File: rtl/counter_chk_pkg.sv
// Shared definitions for counter response checkers: FSM encodings and default widths.
package counter_chk_pkg;

  localparam int DEF_WIDTH     = 3;
  localparam int DEF_CNT_WIDTH = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CHECK = 2'd1;
  localparam logic [1:0] ST_FAIL  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    CHECK = ST_CHECK,
    FAIL  = ST_FAIL
  } state_e;

endpackage

// File: rtl/counter_ref_model.sv
// Reference model of a loadable/incrementing counter: registered expected value,
// optional resync to an observed value, and a wrap pulse on the all-ones -> 0 increment.
module counter_ref_model
  import counter_chk_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hold,
  input  logic             ld,
  input  logic             inc,
  input  logic [WIDTH-1:0] data_in,
  input  logic             resync,
  input  logic [WIDTH-1:0] resync_value,
  output logic [WIDTH-1:0] exp_value,
  output logic             wrap
);

  logic [WIDTH-1:0] base;
  logic [WIDTH-1:0] next_value;
  logic             wrap_next;

  // The next-value function runs from the observed value when resyncing, so one
  // glitch costs one mismatch instead of a mismatch on every later cycle.
  always_comb begin
    base       = resync ? resync_value : exp_value;
    next_value = base;
    wrap_next  = 1'b0;
    if (ld) begin
      next_value = data_in;
    end else if (inc) begin
      next_value = base + 1'b1;
      wrap_next  = &base;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values, regardless of the order statements appear in.
  always_ff @(posedge clk) begin
    if (rst) begin
      exp_value <= '0;
      wrap      <= 1'b0;
    end else if (hold) begin
      wrap      <= 1'b0;
    end else begin
      exp_value <= next_value;
      wrap      <= wrap_next;
    end
  end

endmodule

// File: rtl/counter_checker.sv
// Response checker for a loadable/incrementing counter: tracks a reference model and
// flags, counts and captures every cycle where the observed output diverges from it.
module counter_checker
  import counter_chk_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int CNT_WIDTH   = DEF_CNT_WIDTH,
  parameter int STOP_ON_ERR = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 ld,
  input  logic                 inc,
  input  logic [WIDTH-1:0]     data_in,
  input  logic [WIDTH-1:0]     data_out,
  output logic [WIDTH-1:0]     exp_value,
  output logic                 mismatch,
  output logic                 err_sticky,
  output logic [CNT_WIDTH-1:0] err_count,
  output logic                 wrap,
  output logic [WIDTH-1:0]     first_exp,
  output logic [WIDTH-1:0]     first_obs
);

  logic [1:0] state_q;
  logic [1:0] state_d;
  logic       fail;
  logic       resync;
  logic       hold;

  assign fail   = (state_q == ST_CHECK) && en && (data_out != exp_value);
  assign resync = fail && (STOP_ON_ERR == 0);
  assign hold   = (state_q == ST_FAIL);

  // NOTE: state_d gets a default before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  state_d = ST_CHECK;
      ST_CHECK: if (fail && (STOP_ON_ERR != 0)) state_d = ST_FAIL;
      ST_FAIL:  state_d = ST_FAIL;
      default:  state_d = ST_IDLE;
    endcase
  end

  counter_ref_model #(
    .WIDTH(WIDTH)
  ) u_model (
    .clk          (clk),
    .rst          (rst),
    .hold         (hold),
    .ld           (ld),
    .inc          (inc),
    .data_in      (data_in),
    .resync       (resync),
    .resync_value (data_out),
    .exp_value    (exp_value),
    .wrap         (wrap)
  );

  // fail is zero in FAIL, so the error registers freeze there without extra gating.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      mismatch   <= 1'b0;
      err_sticky <= 1'b0;
      err_count  <= '0;
      first_exp  <= '0;
      first_obs  <= '0;
    end else begin
      state_q  <= state_d;
      mismatch <= fail;
      if (fail) begin
        err_sticky <= 1'b1;
        if (err_count != '1) err_count <= err_count + 1'b1;
        if (!err_sticky) begin
          first_exp <= exp_value;
          first_obs <= data_out;
        end
      end
    end
  end

endmodule

// File: tb/tb_counter_checker.sv
// Scoreboard bench for counter_checker: one resyncing and one stop-on-error instance
// share stimulus and are compared every cycle against a behavioural model.
module tb_counter_checker;

  typedef enum int {P_IDLE, P_CHECK, P_FAIL} phase_e;

  typedef struct {
    int exp_value;
    bit mismatch;
    bit sticky;
    int count;
    bit wrap;
    int fe;
    int fo;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst, en, ld, inc;
  logic [2:0] data_in, data_out;

  logic [2:0] exp0, exp1, fe0, fe1, fo0, fo1;
  logic       mm0, mm1, st0, st1, wr0, wr1;
  logic [7:0] ec0, ec1;

  int tests = 0;
  int fails = 0;

  phase_e ph[2];
  int     mexp[2], mcnt[2], mfe[2], mfo[2];
  bit     mstk[2];
  int     cnt = 0;
  exp_t   q0[$], q1[$];

  always #5 clk = ~clk;

  counter_checker #(.WIDTH(3), .CNT_WIDTH(8), .STOP_ON_ERR(0)) dut0 (
    .clk(clk), .rst(rst), .en(en), .ld(ld), .inc(inc), .data_in(data_in),
    .data_out(data_out), .exp_value(exp0), .mismatch(mm0), .err_sticky(st0),
    .err_count(ec0), .wrap(wr0), .first_exp(fe0), .first_obs(fo0)
  );

  counter_checker #(.WIDTH(3), .CNT_WIDTH(8), .STOP_ON_ERR(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .ld(ld), .inc(inc), .data_in(data_in),
    .data_out(data_out), .exp_value(exp1), .mismatch(mm1), .err_sticky(st1),
    .err_count(ec1), .wrap(wr1), .first_exp(fe1), .first_obs(fo1)
  );

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, req, $time);
    end
  endtask

  // Spec-level behaviour of one checker; k=0 resyncs on error, k=1 stops on error.
  task automatic step_model(input int k, input bit r, input bit e, input bit l,
                            input bit i, input int din, input int dout, output exp_t x);
    int base;
    bit fail;
    x.mismatch = 0;
    x.wrap     = 0;
    if (r) begin
      ph[k] = P_IDLE; mexp[k] = 0; mcnt[k] = 0; mfe[k] = 0; mfo[k] = 0; mstk[k] = 0;
    end else if (ph[k] != P_FAIL) begin
      fail = (ph[k] == P_CHECK) && e && (dout != mexp[k]);
      base = (fail && k == 0) ? dout : mexp[k];
      x.mismatch = fail;
      x.wrap     = !l && i && (base == 7);
      if (fail) begin
        if (!mstk[k]) begin
          mfe[k] = mexp[k];
          mfo[k] = dout;
        end
        mstk[k] = 1;
        if (mcnt[k] < 255) mcnt[k]++;
      end
      if (ph[k] == P_IDLE) ph[k] = P_CHECK;
      else if (fail && k == 1) ph[k] = P_FAIL;
      mexp[k] = l ? din : (i ? (base + 1) % 8 : base);
    end
    x.exp_value = mexp[k];
    x.sticky    = mstk[k];
    x.count     = mcnt[k];
    x.fe        = mfe[k];
    x.fo        = mfo[k];
  endtask

  // mode 0: correct counter; 1: counter itself jumps to val; 2: bus shows val for one cycle only.
  task automatic cycle(input bit r, input bit e, input bit l, input bit i,
                       input int din, input int mode, input int val);
    exp_t x0, x1;
    int   shown;
    @(negedge clk);
    if (mode == 1) cnt = val % 8;
    shown    = (mode == 2) ? val % 8 : cnt;
    rst      = r;
    en       = e;
    ld       = l;
    inc      = i;
    data_in  = 3'(din);
    data_out = 3'(shown);
    step_model(0, r, e, l, i, din % 8, shown, x0);
    step_model(1, r, e, l, i, din % 8, shown, x1);
    q0.push_back(x0);
    q1.push_back(x1);
    cnt = r ? 0 : (l ? din % 8 : (i ? (cnt + 1) % 8 : cnt));
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic cmp(input string tag, input exp_t x, input logic [2:0] ev, input logic mm,
                     input logic st, input logic [7:0] ec, input logic wr,
                     input logic [2:0] fe, input logic [2:0] fo);
    check({tag, ".exp_value"},  int'(ev), x.exp_value);
    check({tag, ".mismatch"},   int'(mm), int'(x.mismatch));
    check({tag, ".err_sticky"}, int'(st), int'(x.sticky));
    check({tag, ".err_count"},  int'(ec), x.count);
    check({tag, ".wrap"},       int'(wr), int'(x.wrap));
    check({tag, ".first_exp"},  int'(fe), x.fe);
    check({tag, ".first_obs"},  int'(fo), x.fo);
  endtask

  // Monitor: every registered output is presented after each posedge.
  initial begin
    exp_t x0, x1;
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() != 0) begin
        x0 = q0.pop_front();
        x1 = q1.pop_front();
        cmp("resync", x0, exp0, mm0, st0, ec0, wr0, fe0, fo0);
        cmp("stop",   x1, exp1, mm1, st1, ec1, wr1, fe1, fo1);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b0; ld = 1'b0; inc = 1'b0; data_in = '0; data_out = '0;

    // Reset then a free-running correct counter through one wrap.
    repeat (2) cycle(1, 1, 0, 0, 0, 0, 0);
    repeat (10) cycle(0, 1, 0, 1, 0, 0, 0);

    // Load 5 then count 5,6,7,0.
    cycle(1, 1, 0, 0, 0, 0, 0);
    cycle(0, 1, 1, 0, 5, 0, 0);
    repeat (3) cycle(0, 1, 0, 1, 0, 0, 0);

    // Counter jumps to 3 while the model holds 2.
    repeat (2) cycle(1, 1, 0, 0, 0, 0, 0);
    repeat (2) cycle(0, 1, 0, 1, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 1, 3);
    repeat (5) cycle(0, 1, 0, 1, 0, 0, 0);
    settle();
    check("glitch.err_count",  int'(ec0), 1);
    check("glitch.first_exp",  int'(fe0), 2);
    check("glitch.first_obs",  int'(fo0), 3);
    check("glitch.stop_count", int'(ec1), 1);
    check("glitch.stop_stky",  int'(st1), 1);

    // 300 back-to-back failures saturate the counter without touching the first capture.
    repeat (300) cycle(0, 1, 0, 0, 0, 1, cnt + 1);
    repeat (3) cycle(0, 1, 0, 1, 0, 0, 0);
    settle();
    check("sat.err_count",  int'(ec0), 255);
    check("sat.first_exp",  int'(fe0), 2);
    check("sat.first_obs",  int'(fo0), 3);
    check("sat.stop_count", int'(ec1), 1);

    // A single reset clears everything, including the sticky flag.
    cycle(1, 1, 0, 0, 0, 0, 0);
    settle();
    check("rst.stop_exp",   int'(exp1), 0);
    check("rst.stop_count", int'(ec1), 0);
    check("rst.stop_stky",  int'(st1), 0);
    check("rst.count",      int'(ec0), 0);
    check("rst.first_obs",  int'(fo0), 0);

    // Glitch while disabled, then resume with a correct counter.
    cycle(1, 1, 0, 0, 0, 0, 0);
    repeat (3) cycle(0, 1, 0, 1, 0, 0, 0);
    cycle(0, 0, 0, 1, 0, 2, 6);
    repeat (6) cycle(0, 1, 0, 1, 0, 0, 0);
    settle();
    check("en_off.count", int'(ec0), 0);
    check("en_off.stky",  int'(st0), 0);

    // Randomised traffic with occasional resets and both kinds of glitch.
    for (int n = 0; n < 2000; n++) begin
      int m, md;
      m  = int'($urandom_range(0, 19));
      md = (m == 0) ? 1 : ((m == 1) ? 2 : 0);
      cycle(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) != 0),
            ($urandom_range(0, 4) == 0), bit'($urandom_range(0, 1)),
            int'($urandom_range(0, 7)), md, int'($urandom_range(0, 7)));
    end

    @(posedge clk);
    #3;
    check("scoreboard_drained", q0.size() + q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
